// File: rtl/uart_rx_edge_sampler.sv
// UART RX edge sampler: line synchroniser, oversampling edge/bit counters
// and a 3-sample majority voter feeding the RX FSM.
module uart_rx_edge_sampler #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESCALE_W  = 5
) (
    input  logic                  clk_smp,
    input  logic                  rst_smp,
    input  logic                  RX_IN_smp,
    input  logic [PRESCALE_W-1:0] prescale_smp,
    input  logic                  edge_bit_en_smp,
    input  logic                  data_samp_en_smp,
    output logic                  rx_sync_smp,
    output logic [PRESCALE_W-1:0] edge_count_smp,
    output logic [3:0]            bit_count_smp,
    output logic                  sampled_bit_smp,
    output logic                  sample_valid_smp
);

    localparam int unsigned CW = PRESCALE_W + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             samp_q;

    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_m1;
    logic [PRESCALE_W-1:0] mid_p1;
    logic [CW-1:0]         mid_p2_w;
    logic [CW-1:0]         p_eff_w;
    logic                  vote_wraps;
    logic [PRESCALE_W-1:0] vote_pt;
    logic                  vote_hit;
    logic                  majority;

    // Effective prescale is clamped to 4 so the three mid-bit samples always fit.
    assign p_eff  = (prescale_smp < PRESCALE_W'(4)) ? PRESCALE_W'(4) : prescale_smp;
    assign p_last = p_eff - PRESCALE_W'(1);
    assign mid    = p_eff >> 1;
    assign mid_m1 = mid - PRESCALE_W'(1);
    assign mid_p1 = mid + PRESCALE_W'(1);

    // Vote point m+2; when it falls past the bit (P=4) it lands on edge 0 of the
    // next bit and is only taken once a previous bit exists to credit it to.
    assign mid_p2_w   = CW'(mid) + CW'(2);
    assign p_eff_w    = CW'(p_eff);
    assign vote_wraps = (mid_p2_w >= p_eff_w);
    assign vote_pt    = vote_wraps ? PRESCALE_W'(mid_p2_w - p_eff_w) : PRESCALE_W'(mid_p2_w);
    assign vote_hit   = (edge_count_smp == vote_pt) &&
                        (!vote_wraps || (bit_count_smp != 4'd0));

    assign majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                      (samp_q[1] & samp_q[2]);

    assign rx_sync_smp = sync_q[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous serial line; idles high.
    always_ff @(posedge clk_smp) begin
        if (rst_smp) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN_smp};
        end
    end

    // Edge and bit counters; >= compare keeps a mid-frame prescale drop safe.
    always_ff @(posedge clk_smp) begin
        if (rst_smp) begin
            edge_count_smp <= '0;
            bit_count_smp  <= 4'd0;
        end else if (!edge_bit_en_smp) begin
            edge_count_smp <= '0;
            bit_count_smp  <= 4'd0;
        end else if (edge_count_smp >= p_last) begin
            edge_count_smp <= '0;
            if (bit_count_smp != 4'hf) begin
                bit_count_smp <= bit_count_smp + 4'd1;
            end
        end else begin
            edge_count_smp <= edge_count_smp + PRESCALE_W'(1);
        end
    end

    // Mid-bit sample capture and majority vote.
    always_ff @(posedge clk_smp) begin
        if (rst_smp) begin
            samp_q           <= 3'b111;
            sampled_bit_smp  <= 1'b1;
            sample_valid_smp <= 1'b0;
        end else if (!data_samp_en_smp) begin
            samp_q           <= 3'b111;
            sample_valid_smp <= 1'b0;
        end else begin
            if (edge_count_smp == mid_m1) begin
                samp_q[0] <= rx_sync_smp;
            end
            if (edge_count_smp == mid) begin
                samp_q[1] <= rx_sync_smp;
            end
            if (edge_count_smp == mid_p1) begin
                samp_q[2] <= rx_sync_smp;
            end
            sample_valid_smp <= vote_hit;
            if (vote_hit) begin
                sampled_bit_smp <= majority;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed self-checking bench for uart_rx_edge_sampler.
module tb_uart_rx_edge_sampler;

    logic       clk_smp;
    logic       rst_smp;
    logic       RX_IN_smp;
    logic [4:0] prescale_smp;
    logic       edge_bit_en_smp;
    logic       data_samp_en_smp;
    logic       rx_sync_smp;
    logic [4:0] edge_count_smp;
    logic [3:0] bit_count_smp;
    logic       sampled_bit_smp;
    logic       sample_valid_smp;

    int n_cmp;
    int n_err;
    int n_pulse;
    logic [9:0] frame;

    uart_rx_edge_sampler #(.SYNC_STAGES(2), .PRESCALE_W(5)) dut (
        .clk_smp          (clk_smp),
        .rst_smp          (rst_smp),
        .RX_IN_smp        (RX_IN_smp),
        .prescale_smp     (prescale_smp),
        .edge_bit_en_smp  (edge_bit_en_smp),
        .data_samp_en_smp (data_samp_en_smp),
        .rx_sync_smp      (rx_sync_smp),
        .edge_count_smp   (edge_count_smp),
        .bit_count_smp    (bit_count_smp),
        .sampled_bit_smp  (sampled_bit_smp),
        .sample_valid_smp (sample_valid_smp)
    );

    initial clk_smp = 1'b0;
    always #5 clk_smp = ~clk_smp;

    task automatic tick();
        @(posedge clk_smp);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rx_sync"}, int'(rx_sync_smp), 1);
        chk({tag, "_edge"}, int'(edge_count_smp), 0);
        chk({tag, "_bit"}, int'(bit_count_smp), 0);
        chk({tag, "_sampled"}, int'(sampled_bit_smp), 1);
        chk({tag, "_valid"}, int'(sample_valid_smp), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        frame = {1'b1, 8'h5A, 1'b0};
        rst_smp = 1'b1;
        RX_IN_smp = 1'b0;
        prescale_smp = 5'd8;
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;

        // Reset held with the line toggling.
        for (int i = 0; i < 4; i++) begin
            RX_IN_smp = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk_reset_state("reset");
        end
        rst_smp = 1'b0;
        RX_IN_smp = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // P=8: one low bit then high; counters, sync lag and vote latency.
        prescale_smp = 5'd8;
        edge_bit_en_smp = 1'b1;
        data_samp_en_smp = 1'b1;
        RX_IN_smp = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("p8_edge", int'(edge_count_smp), i % 8);
            chk("p8_bit", int'(bit_count_smp), i / 8);
            chk("p8_rx_sync", int'(rx_sync_smp), (i >= 2 && i <= 9) ? 0 : 1);
            chk("p8_valid", int'(sample_valid_smp), (i == 7 || i == 15) ? 1 : 0);
            chk("p8_sampled", int'(sampled_bit_smp), (i >= 7 && i < 15) ? 0 : 1);
            if (i == 8) RX_IN_smp = 1'b1;
        end
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;
        tick();
        chk("p8_clear_edge", int'(edge_count_smp), 0);
        tick();

        // P=16 frame 0x5A, LSB first, no parity.
        prescale_smp = 5'd16;
        edge_bit_en_smp = 1'b1;
        data_samp_en_smp = 1'b1;
        RX_IN_smp = frame[0];
        n_pulse = 0;
        for (int i = 1; i <= 159; i++) begin
            tick();
            chk("frm_bit", int'(bit_count_smp), i / 16);
            chk("frm_valid", int'(sample_valid_smp), (i % 16 == 11) ? 1 : 0);
            if (i % 16 == 11) begin
                n_pulse++;
                chk("frm_sampled", int'(sampled_bit_smp), int'(frame[i / 16]));
            end
            RX_IN_smp = frame[((i + 2) / 16 > 9) ? 9 : (i + 2) / 16];
        end
        chk("frm_pulses", n_pulse, 10);
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;
        RX_IN_smp = 1'b1;
        tick();
        tick();

        // P=8 glitches: 1-cycle at edge 4 of a low bit, then 2-cycle at edges 4-5.
        prescale_smp = 5'd8;
        edge_bit_en_smp = 1'b1;
        data_samp_en_smp = 1'b1;
        RX_IN_smp = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 7) begin
                chk("glitch1_valid", int'(sample_valid_smp), 1);
                chk("glitch1_sampled", int'(sampled_bit_smp), 0);
            end
            if (i == 8) chk("glitch_valid_off", int'(sample_valid_smp), 0);
            if (i == 15) begin
                chk("glitch2_valid", int'(sample_valid_smp), 1);
                chk("glitch2_sampled", int'(sampled_bit_smp), 1);
            end
            RX_IN_smp = (i == 2 || i == 10 || i == 11) ? 1'b1 : 1'b0;
        end
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;
        RX_IN_smp = 1'b1;
        tick();
        tick();
        tick();

        // edge_bit_en dropped at edge 5 of bit 3.
        edge_bit_en_smp = 1'b1;
        data_samp_en_smp = 1'b1;
        for (int i = 1; i <= 29; i++) tick();
        chk("drop_pre_edge", int'(edge_count_smp), 5);
        chk("drop_pre_bit", int'(bit_count_smp), 3);
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;
        tick();
        chk("drop_edge", int'(edge_count_smp), 0);
        chk("drop_bit", int'(bit_count_smp), 0);
        chk("drop_valid", int'(sample_valid_smp), 0);
        // Counting with the sampler disabled gives no pulses, value holds.
        edge_bit_en_smp = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("nosamp_valid", int'(sample_valid_smp), 0);
        end
        chk("nosamp_hold", int'(sampled_bit_smp), 1);
        edge_bit_en_smp = 1'b0;
        tick();

        // Prescale 16 -> 8 while edge_count is 12.
        prescale_smp = 5'd16;
        edge_bit_en_smp = 1'b1;
        for (int i = 1; i <= 12; i++) tick();
        chk("pchg_pre_edge", int'(edge_count_smp), 12);
        prescale_smp = 5'd8;
        tick();
        chk("pchg_wrap_edge", int'(edge_count_smp), 0);
        chk("pchg_wrap_bit", int'(bit_count_smp), 1);
        for (int i = 1; i <= 7; i++) tick();
        chk("pchg_p8_edge", int'(edge_count_smp), 7);
        tick();
        chk("pchg_p8_wrap_edge", int'(edge_count_smp), 0);
        chk("pchg_p8_wrap_bit", int'(bit_count_smp), 2);
        edge_bit_en_smp = 1'b0;
        RX_IN_smp = 1'b0;
        tick();
        tick();
        tick();

        // prescale=2 behaves as P=4; vote for bit 0 lands on edge 0 of bit 1.
        prescale_smp = 5'd2;
        edge_bit_en_smp = 1'b1;
        data_samp_en_smp = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("p4_edge", int'(edge_count_smp), i % 4);
            chk("p4_bit", int'(bit_count_smp), i / 4);
            if (i == 5) begin
                chk("p4_valid", int'(sample_valid_smp), 1);
                chk("p4_sampled", int'(sampled_bit_smp), 0);
            end
        end
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;
        RX_IN_smp = 1'b1;
        tick();
        tick();

        // Reset mid-frame with the line low.
        prescale_smp = 5'd8;
        edge_bit_en_smp = 1'b1;
        data_samp_en_smp = 1'b1;
        RX_IN_smp = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        chk("mid_pre_sampled", int'(sampled_bit_smp), 0);
        rst_smp = 1'b1;
        tick();
        chk_reset_state("midrst");
        tick();
        chk_reset_state("midrst_hold");
        rst_smp = 1'b0;
        edge_bit_en_smp = 1'b0;
        data_samp_en_smp = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
